mips_mc_ctrl_fsm: RTL and testbench

Main control state machine for the multicycle MIPS datapath. Decodes the 6-bit opcode from the instruction register and sequences the datapath through fetch, decode, execute, memory and writeback steps, one step per clock. Drives all datapath enables and mux selects, and produces the 2-bit `ALUOp` consumed by the funct-field ALU control decoder. The block is the producer end of the `ALUOp` interface.

---
 rtl/mips_mc_ctrl_fsm.sv | 205 ++++++++++++++++++++
 tb/tb_mips_mc_ctrl_fsm.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_ctrl_fsm.sv
// rtl/mips_mc_ctrl_fsm.sv - multicycle MIPS main control FSM (optional BNE state via MC_CTRL_BNE_EN)
module mips_mc_ctrl_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic       zero,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       illegal_op,
    output logic       retire,
    output logic [3:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef MC_CTRL_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BEQ      = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
`ifdef MC_CTRL_BNE_EN
        ,
        S_BNE      = 4'd12
`endif
    } state_t;

    state_t cur_state;
    state_t nxt_state;

    // Internal enables before the reset gate is applied.
    logic pc_write;
    logic branch;
    logic branch_ne;
    logic irwrite_raw;
    logic memwrite_raw;
    logic regwrite_raw;
    logic retire_raw;

    // State register; reset always lands in FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= S_FETCH;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state logic; op is only consulted in DECODE and MEMADR.
    always_comb begin
        nxt_state = S_FETCH;
        case (cur_state)
            S_FETCH: nxt_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: nxt_state = S_MEMADR;
                    OP_RTYPE:     nxt_state = S_EXECUTE;
                    OP_BEQ:       nxt_state = S_BEQ;
                    OP_ADDI:      nxt_state = S_ADDIEX;
                    OP_J:         nxt_state = S_JUMP;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE:       nxt_state = S_BNE;
`endif
                    default:      nxt_state = S_FETCH;
                endcase
            end
            S_MEMADR:   nxt_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  nxt_state = S_MEMWB;
            S_EXECUTE:  nxt_state = S_ALUWB;
            S_ADDIEX:   nxt_state = S_ADDIWB;
            default:    nxt_state = S_FETCH;
        endcase
    end

    // Moore outputs per state, plus the DECODE illegal-op flag; undefined codes drive all zeros.
    always_comb begin
        IorD         = 1'b0;
        memwrite_raw = 1'b0;
        irwrite_raw  = 1'b0;
        RegDst       = 1'b0;
        MemtoReg     = 1'b0;
        regwrite_raw = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        ALUOp        = 2'b00;
        PCSrc        = 2'b00;
        pc_write     = 1'b0;
        branch       = 1'b0;
        branch_ne    = 1'b0;
        illegal_op   = 1'b0;
        retire_raw   = 1'b0;
        case (cur_state)
            S_FETCH: begin
                irwrite_raw = 1'b1;
                pc_write    = 1'b1;
                ALUSrcB     = 2'b01;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (op)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE: illegal_op = 1'b0;
`endif
                    default: illegal_op = 1'b1;
                endcase
                retire_raw = illegal_op;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMREAD: begin
                IorD = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg     = 1'b1;
                regwrite_raw = 1'b1;
                retire_raw   = 1'b1;
            end
            S_MEMWRITE: begin
                IorD         = 1'b1;
                memwrite_raw = 1'b1;
                retire_raw   = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_ALUWB: begin
                RegDst       = 1'b1;
                regwrite_raw = 1'b1;
                retire_raw   = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA    = 1'b1;
                ALUOp      = 2'b01;
                PCSrc      = 2'b01;
                branch     = 1'b1;
                retire_raw = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDIWB: begin
                regwrite_raw = 1'b1;
                retire_raw   = 1'b1;
            end
            S_JUMP: begin
                PCSrc      = 2'b10;
                pc_write   = 1'b1;
                retire_raw = 1'b1;
            end
`ifdef MC_CTRL_BNE_EN
            S_BNE: begin
                ALUSrcA    = 1'b1;
                ALUOp      = 2'b01;
                PCSrc      = 2'b01;
                branch_ne  = 1'b1;
                retire_raw = 1'b1;
            end
`endif
            default: begin
                IorD = 1'b0;
            end
        endcase
    end

    // Enables are suppressed while reset is held so an abandoned instruction writes nothing.
    always_comb begin
        IRWrite  = irwrite_raw & ~rst;
        MemWrite = memwrite_raw & ~rst;
        RegWrite = regwrite_raw & ~rst;
        retire   = retire_raw & ~rst;
        PCEn     = (pc_write | (branch & zero) | (branch_ne & ~zero)) & ~rst;
    end

    assign state = cur_state;

endmodule

// File: tb/tb_mips_mc_ctrl_fsm.sv
// tb/tb_mips_mc_ctrl_fsm.sv - randomized model-checked bench for mips_mc_ctrl_fsm
module tb_mips_mc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = 6'd0;
    logic       zero = 1'b0;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic       PCEn, illegal_op, retire;
    logic [3:0] state;

    mips_mc_ctrl_fsm dut (
        .clk(clk), .rst(rst), .op(op), .zero(zero),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .PCEn(PCEn),
        .illegal_op(illegal_op), .retire(retire), .state(state)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
    localparam logic [5:0] BNE = 6'b000101, BAD = 6'b111111;

    int vectors = 0;
    int miscompares = 0;
    int exp_s = -1;
    bit chk = 0;
    int seq[$];

    function automatic bit bne_on();
`ifdef MC_CTRL_BNE_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Step-count table for one instruction, derived from the opcode's datapath recipe.
    task automatic build_seq(input logic [5:0] o);
        seq.delete();
        seq.push_back(0);
        seq.push_back(1);
        if (o == LW)        begin seq.push_back(2); seq.push_back(3); seq.push_back(4); end
        else if (o == SW)   begin seq.push_back(2); seq.push_back(5); end
        else if (o == RT)   begin seq.push_back(6); seq.push_back(7); end
        else if (o == BEQ)  seq.push_back(8);
        else if (o == ADDI) begin seq.push_back(9); seq.push_back(10); end
        else if (o == JMP)  seq.push_back(11);
        else if (o == BNE && bne_on()) seq.push_back(12);
    endtask

    // Expected output vector for a step: {state, IorD, MemWrite, IRWrite, RegDst, MemtoReg,
    // RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn, illegal_op, retire}.
    function automatic logic [19:0] model(int s, logic z, logic [5:0] o, logic r);
        logic iord = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, sa = 0;
        logic [1:0] sb = 0, ao = 0, ps = 0;
        logic pcw = 0, br = 0, bn = 0, ill = 0, ret = 0, pcen;
        bit legal;
        legal = (o == LW) || (o == SW) || (o == RT) || (o == BEQ) || (o == ADDI) ||
                (o == JMP) || (o == BNE && bne_on());
        case (s)
            0:  begin irw = 1; pcw = 1; sb = 2'b01; end
            1:  begin sb = 2'b11; ill = !legal; ret = !legal; end
            2:  begin sa = 1; sb = 2'b10; end
            3:  iord = 1;
            4:  begin m2r = 1; rw = 1; ret = 1; end
            5:  begin iord = 1; mw = 1; ret = 1; end
            6:  begin sa = 1; ao = 2'b10; end
            7:  begin rd = 1; rw = 1; ret = 1; end
            8:  begin sa = 1; ao = 2'b01; ps = 2'b01; br = 1; ret = 1; end
            9:  begin sa = 1; sb = 2'b10; end
            10: begin rw = 1; ret = 1; end
            11: begin ps = 2'b10; pcw = 1; ret = 1; end
            12: begin sa = 1; ao = 2'b01; ps = 2'b01; bn = 1; ret = 1; end
            default: ;
        endcase
        pcen = pcw | (br & z) | (bn & ~z);
        if (r) begin irw = 0; mw = 0; rw = 0; pcen = 0; ret = 0; end
        return {s[3:0], iord, mw, irw, rd, m2r, rw, sa, sb, ao, ps, pcen, ill, ret};
    endfunction

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [19:0] got, expv;
        if (chk) begin
            expv = model(exp_s, zero, op, rst);
            got = {state, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                   ALUSrcB, ALUOp, PCSrc, PCEn, illegal_op, retire};
            vectors++;
            if (got !== expv) begin
                miscompares++;
                $display("FAIL outputs t=%0t step=%0d op=%b zero=%b rst=%b got=%h required=%h",
                         $time, exp_s, op, zero, rst, got, expv);
            end
        end
    end

    // Start one cycle: drive inputs just after the edge, leave time to settle.
    task automatic cyc(input logic r, input logic [5:0] o, input logic z, input int s);
        @(posedge clk);
        #1;
        rst = r; op = o; zero = z; exp_s = s; chk = (s >= 0);
        #2;
    endtask

    task automatic lit(input string name, input int got, input int expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("FAIL %s got=%0d required=%0d", name, got, expv);
        end
    endtask

    task automatic run_instr(input logic [5:0] o, input bit allow_abort);
        int abort_at;
        build_seq(o);
        abort_at = (allow_abort && ($urandom_range(0, 19) == 0)) ?
                   int'($urandom_range(1, seq.size() - 1)) : -1;
        for (int i = 0; i < seq.size(); i++) begin
            if (i == abort_at) begin
                cyc(1'b1, o, 1'($urandom), seq[i]);
                break;
            end
            cyc(1'b0, o, 1'($urandom), seq[i]);
        end
    endtask

    initial begin
        logic [5:0] rop;
        cyc(1'b1, RT, 1'b0, -1);
        cyc(1'b1, RT, 1'b0, 0);
        lit("reset_state", state, 0);
        lit("reset_alusrcb", ALUSrcB, 1);
        lit("reset_pcen", PCEn, 0);

        // Reset held in JUMP for three cycles, then a lw.
        cyc(1'b0, JMP, 1'b0, 0);
        cyc(1'b0, JMP, 1'b0, 1);
        cyc(1'b1, JMP, 1'b0, 11);
        lit("rst_in_jump_pcen", PCEn, 0);
        lit("rst_in_jump_retire", retire, 0);
        cyc(1'b1, JMP, 1'b0, 0);
        lit("rst_held_irwrite", IRWrite, 0);
        cyc(1'b1, JMP, 1'b0, 0);
        lit("rst_held_state", state, 0);
        cyc(1'b0, LW, 1'b0, 0);
        lit("first_fetch_irwrite", IRWrite, 1);
        lit("first_fetch_pcen", PCEn, 1);
        cyc(1'b0, LW, 1'b0, 1);
        lit("lw_decode_retire", retire, 0);
        cyc(1'b0, LW, 1'b0, 2);
        cyc(1'b0, LW, 1'b0, 3);
        lit("lw_memread_iord", IorD, 1);
        cyc(1'b0, LW, 1'b0, 4);
        lit("lw_memwb_memtoreg", MemtoReg, 1);
        lit("lw_memwb_retire", retire, 1);

        // R-type then addi.
        cyc(1'b0, RT, 1'b0, 0);
        cyc(1'b0, RT, 1'b0, 1);
        cyc(1'b0, RT, 1'b0, 6);
        lit("rtype_aluop", ALUOp, 2);
        cyc(1'b0, RT, 1'b0, 7);
        lit("rtype_regdst", RegDst, 1);
        run_instr(ADDI, 0);

        // beq taken and not taken.
        cyc(1'b0, BEQ, 1'b1, 0);
        cyc(1'b0, BEQ, 1'b1, 1);
        cyc(1'b0, BEQ, 1'b1, 8);
        lit("beq_taken_pcen", PCEn, 1);
        lit("beq_pcsrc", PCSrc, 1);
        lit("beq_aluop", ALUOp, 1);
        cyc(1'b0, BEQ, 1'b0, 0);
        cyc(1'b0, BEQ, 1'b0, 1);
        cyc(1'b0, BEQ, 1'b0, 8);
        lit("beq_not_taken_pcen", PCEn, 0);

        // Unsupported opcode: two-cycle instruction, no write enables.
        cyc(1'b0, BAD, 1'b0, 0);
        cyc(1'b0, BAD, 1'b0, 1);
        lit("bad_illegal", illegal_op, 1);
        lit("bad_retire", retire, 1);
        lit("bad_regwrite", RegWrite, 0);

        // 000101: branch-not-equal when enabled, unsupported otherwise.
`ifdef MC_CTRL_BNE_EN
        cyc(1'b0, BNE, 1'b0, 0);
        cyc(1'b0, BNE, 1'b0, 1);
        cyc(1'b0, BNE, 1'b0, 12);
        lit("bne_taken_pcen", PCEn, 1);
        cyc(1'b0, BNE, 1'b1, 0);
        cyc(1'b0, BNE, 1'b1, 1);
        cyc(1'b0, BNE, 1'b1, 12);
        lit("bne_not_taken_pcen", PCEn, 0);
`else
        cyc(1'b0, BNE, 1'b0, 0);
        cyc(1'b0, BNE, 1'b0, 1);
        lit("bne_off_illegal", illegal_op, 1);
        lit("bne_off_retire", retire, 1);
        cyc(1'b0, BNE, 1'b0, 0);
        lit("bne_off_back_to_fetch", state, 0);
        cyc(1'b0, BNE, 1'b0, 1);
`endif

        // Randomized instruction stream with occasional mid-instruction reset.
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0: rop = LW;
                1: rop = SW;
                2: rop = RT;
                3: rop = BEQ;
                4: rop = ADDI;
                5: rop = JMP;
                6: rop = BNE;
                default: rop = 6'($urandom);
            endcase
            run_instr(rop, 1);
        end

        @(posedge clk);
        #1;
        chk = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
